fp_conv_issue_buffer: RTL and testbench

FP_CONV_ISSUE_BUFFER -- requirements
Module: fp_conv_issue_buffer

---
 rtl/fp_conv_issue_buffer.sv | 88 ++++++++
 tb/tb_fp_conv_issue_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_conv_issue_buffer.sv
// Issue/return buffer for a fixed-latency UInt-to-float converter: tracks in-flight
// operations in a tag pipeline and parks their results in a FIFO sized to what was admitted.
module fp_conv_issue_buffer #(
  parameter int LATENCY   = 6,
  parameter int DEPTH     = 8,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [31:0]          unit_a,
  input  logic [31:0]          unit_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [6:0]           occupancy
);
  localparam int            PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            SW        = TAG_WIDTH + 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [6:0]    DEPTH_CNT = 7'(DEPTH);

  logic [LATENCY-1:0][SW-1:0] stage_reg, stage_next;
  logic [TAG_WIDTH+31:0]      mem [DEPTH];
  logic [PW-1:0]              wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]              rd_ptr_reg, rd_ptr_next;
  logic [6:0]                 count_reg, count_next;
  logic [6:0]                 occ_reg, occ_next;
  logic                       issue, capture, pop;

  // Admission is bounded by occupancy so every in-flight result already owns a FIFO slot.
  assign in_ready  = (occ_reg < DEPTH_CNT) && !areset;
  assign issue     = in_valid && in_ready;
  assign unit_a    = in_data;
  assign capture   = stage_reg[LATENCY-1][SW-1];
  assign out_valid = (count_reg != 7'd0);
  assign pop       = out_valid && out_ready;
  assign occupancy = occ_reg;
  assign {out_tag, out_data} = mem[rd_ptr_reg];

  assign stage_next[0] = {issue, in_tag};
  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (capture)
      wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
    if (pop)
      rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
    count_next = count_reg + 7'(capture) - 7'(pop);
    occ_next   = occ_reg + 7'(issue) - 7'(pop);
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      stage_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      occ_reg    <= '0;
    end else begin
      stage_reg  <= stage_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      occ_reg    <= occ_next;
    end
  end

  // Result storage stays small, so the head is read straight out of the array.
  always_ff @(posedge clk) begin
    if (capture)
      mem[wr_ptr_reg] <= {stage_reg[LATENCY-1][TAG_WIDTH-1:0], unit_q};
  end

  overflow_a: assert property (@(posedge clk) disable iff (areset)
    !(capture && (count_reg == DEPTH_CNT)));

endmodule

// File: tb/tb_fp_conv_issue_buffer.sv
// Directed bench for fp_conv_issue_buffer with a behavioural converter and a result scoreboard.
module tb_fp_conv_issue_buffer;
  localparam int LAT = 6;
  localparam int DEP = 8;
  localparam int TW  = 5;

  logic          clk = 1'b0;
  logic          areset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [TW-1:0] in_tag;
  logic [31:0]   unit_a;
  logic [31:0]   unit_q;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [TW-1:0] out_tag;
  logic [6:0]    occupancy;

  typedef struct {
    logic [31:0]   data;
    logic [TW-1:0] tag;
    int            exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   track_lat = 1'b0;
  logic [31:0] a_pipe [LAT];

  fp_conv_issue_buffer #(.LATENCY(LAT), .DEPTH(DEP), .TAG_WIDTH(TW)) dut (
    .clk(clk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .unit_a(unit_a), .unit_q(unit_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-to-nearest-even unsigned integer to IEEE-754 single.
  function automatic logic [31:0] u2f(input logic [31:0] x);
    int p;
    int sh;
    logic [63:0] keep;
    logic [63:0] rem;
    logic [63:0] half;
    logic [7:0]  e;
    if (x == 32'd0) return 32'd0;
    p = 31;
    while (p > 0 && !x[p]) p--;
    e = 8'(127 + p);
    if (p <= 23) begin
      keep = 64'(x) << (23 - p);
    end else begin
      sh   = p - 23;
      keep = 64'(x) >> sh;
      rem  = 64'(x) & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
      if (keep[24]) begin
        keep = keep >> 1;
        e    = e + 8'd1;
      end
    end
    return {1'b0, e, keep[22:0]};
  endfunction

  // Converter model: result for an operand appears LAT cycles after it is sampled.
  always @(posedge clk) begin
    a_pipe[0] <= unit_a;
    for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
  end
  assign unit_q = u2f(a_pipe[LAT-1]);

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    chk("drain_occupancy", 64'(occupancy), 64'd0);
  endtask

  // Monitor: handshakes are sampled mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    exp_t e;
    if (areset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          $display("POP   cyc=%0d tag=%0d data=%h", cyc, out_tag, out_data);
          chk("out_data", 64'(out_data), 64'(e.data));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          if (e.exp_cyc >= 0) chk("latency", 64'(cyc), 64'(e.exp_cyc));
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{u2f(in_data), in_tag, track_lat ? cyc + LAT + 1 : -1});
        $display("ISSUE cyc=%0d tag=%0d data=%h", cyc, in_tag, in_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int issue_cyc;
    int n;
    int accepted;
    int seen;
    logic [TW-1:0] tag_ctr;

    areset    = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    areset = 1'b0;
    #1;
    chk("post_reset_out_valid", 64'(out_valid), 64'd0);
    chk("post_reset_occupancy", 64'(occupancy), 64'd0);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Single operation: 1 -> 1.0f after LAT+1 cycles.
    track_lat = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    in_tag    = 5'd3;
    issue_cyc = cyc;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("single_latency", 64'(cyc - issue_cyc), 64'(LAT + 1));
    chk("single_data", 64'(out_data), 64'h3F80_0000);
    chk("single_tag", 64'(out_tag), 64'd3);
    drain(20);

    // Streaming 20 back-to-back operations.
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_tag   = TW'(i);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    drain(40);

    // Backpressure: only DEPTH operations are admitted.
    track_lat = 1'b0;
    out_ready = 1'b0;
    accepted  = 0;
    tag_ctr   = '0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_tag   = tag_ctr;
      tag_ctr  = tag_ctr + 1'b1;
      if (in_ready) accepted++;
      tick();
    end
    chk("bp_accepted", 64'(accepted), 64'(DEP));
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occupancy", 64'(occupancy), 64'(DEP));
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    in_data   = $urandom;
    in_tag    = tag_ctr;
    chk("bp_ready_still_low", 64'(in_ready), 64'd0);
    tick();
    chk("bp_ready_return", 64'(in_ready), 64'd1);
    chk("bp_occ_after_pop", 64'(occupancy), 64'(DEP - 1));
    // Simultaneous issue and pop keeps occupancy constant.
    for (int i = 0; i < 4; i++) begin
      tag_ctr = tag_ctr + 1'b1;
      in_data = $urandom;
      in_tag  = tag_ctr;
      tick();
      chk("simul_occupancy", 64'(occupancy), 64'(DEP - 1));
    end
    in_valid = 1'b0;
    drain(60);

    // Stall: head result must hold while the consumer is not ready.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_tag   = TW'(9 + i);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      if (sb.size() > 0) begin
        chk("stall_out_data", 64'(out_data), 64'(sb[0].data));
        chk("stall_out_tag", 64'(out_tag), 64'(sb[0].tag));
      end
      tick();
    end
    out_ready = 1'b1;
    drain(20);

    // Reset while four operations are in flight.
    track_lat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_tag   = TW'(20 + i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    areset = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    tick();
    areset = 1'b0;
    #1;
    chk("midrst_occupancy", 64'(occupancy), 64'd0);
    chk("midrst_in_ready_back", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (15) begin
      tick();
      if (out_valid) seen++;
    end
    chk("midrst_no_results", 64'(seen), 64'd0);
    chk("midrst_occ_final", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
